// File: rtl/neuron_lane_sigmoid_if.sv
// Start/busy/done handshake bundle for neuron_lane_sigmoid.
// Weight and input vectors are flat, element i at [i*BITS +: BITS].
interface neuron_lane_sigmoid_if #(
    parameter int N    = 30,
    parameter int BITS = 16
) ();
    logic                start;
    logic                mode;
    logic                load_w;
    logic [N*BITS-1:0]   w_in;
    logic [BITS-1:0]     b_in;
    logic [N*BITS-1:0]   x;
    logic [BITS-1:0]     y_true;
    logic [BITS-1:0]     lr;
    logic                busy;
    logic                done;
    logic [BITS-1:0]     y;
    logic [BITS-1:0]     dz;
    logic [N*BITS-1:0]   w_out;
    logic [BITS-1:0]     b_out;

    modport master (
        output start, mode, load_w, w_in, b_in, x, y_true, lr,
        input  busy, done, y, dz, w_out, b_out
    );

    modport slave (
        input  start, mode, load_w, w_in, b_in, x, y_true, lr,
        output busy, done, y, dz, w_out, b_out
    );
endinterface

// File: rtl/neuron_lane_sigmoid.sv
// Fixed-point sigmoid neuron: LANES-wide MAC forward pass, in-place SGD backward pass.
// Define NEURON_SAT_EN to clamp z, dz, g, scaled products and updates instead of wrapping.
module neuron_lane_sigmoid #(
    parameter int N     = 30,
    parameter int BITS  = 16,
    parameter int FRAC  = 8,
    parameter int LANES = 2
) (
    input logic clk,
    input logic rst_n,
    neuron_lane_sigmoid_if.slave bus
);
    localparam int K     = (N + LANES - 1) / LANES;
    localparam int CW    = $clog2(K) + 1;
    localparam int ACCW  = 2 * BITS + $clog2(N) + 1;
    localparam int WIDE  = ACCW + 1;
    localparam int PW    = 2 * BITS;
    localparam int BW1   = BITS + 1;
    localparam int ONE_I = 1 << FRAC;

    localparam logic [BW1-1:0] ONE   = BW1'(ONE_I);
    localparam logic [BW1-1:0] T5    = BW1'(5 * ONE_I);
    localparam logic [BW1-1:0] T2375 = BW1'((19 * ONE_I) / 8);
    localparam logic [BW1-1:0] C84   = BW1'((27 * ONE_I) / 32);
    localparam logic [BW1-1:0] C625  = BW1'((5 * ONE_I) / 8);
    localparam logic [BW1-1:0] CHALF = BW1'(ONE_I / 2);

    typedef enum logic [2:0] {IDLE, FMAC, FACT, BDZ, BUPD, BBIAS} state_t;
    typedef logic signed [BITS-1:0] word_t;
    typedef logic signed [WIDE-1:0] wide_t;

    function automatic word_t fit(input wide_t v);
`ifdef NEURON_SAT_EN
        wide_t hi;
        wide_t lo;
        hi = wide_t'({1'b0, {(BITS-1){1'b1}}});
        lo = -hi - wide_t'(1);
        if (v > hi) return hi[BITS-1:0];
        if (v < lo) return lo[BITS-1:0];
`endif
        return v[BITS-1:0];
    endfunction

    // Piecewise-linear approximation on |z|, mirrored for negative z.
    function automatic word_t sigmoid(input word_t z);
        logic signed [BW1-1:0] zs;
        logic [BW1-1:0] a;
        logic [BW1-1:0] p;
        zs = BW1'(z);
        a = z[BITS-1] ? -zs : zs;
        if (a >= T5)
            p = ONE;
        else if (a >= T2375)
            p = (a >> 5) + C84;
        else if (a >= ONE)
            p = (a >> 3) + C625;
        else
            p = (a >> 2) + CHALF;
        if (z[BITS-1])
            p = ONE - p;
        return p[BITS-1:0];
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    word_t                  w_q [N];
    word_t                  w_d [N];
    word_t                  x_q [N];
    word_t                  x_d [N];
    word_t                  b_q, b_d;
    word_t                  y_q, y_d;
    word_t                  dz_q, dz_d;
    word_t                  g_q, g_d;
    word_t                  yt_q, yt_d;
    word_t                  lr_q, lr_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic                   done_q, done_d;

    word_t                  xl [LANES];
    word_t                  wl [LANES];
    word_t                  wn [LANES];
    word_t                  sp [LANES];
    logic signed [PW-1:0]   prod [LANES];
    logic signed [ACCW-1:0] acc_sum;
    wide_t                  zw;
    word_t                  dz_new;
    word_t                  g_new;

    // Each lane muxes the operands of its element in the current group.
    always_comb begin
        acc_sum = acc_q;
        for (int l = 0; l < LANES; l++) begin
            xl[l] = '0;
            wl[l] = '0;
            for (int i = 0; i < N; i++) begin
                if ((i % LANES) == l && CW'(i / LANES) == cnt_q) begin
                    xl[l] = x_q[i];
                    wl[l] = w_q[i];
                end
            end
            prod[l] = PW'(xl[l]) * PW'(wl[l]);
            acc_sum = acc_sum + ACCW'(prod[l]);
            sp[l] = fit((wide_t'(g_q) * wide_t'(xl[l])) >>> FRAC);
            wn[l] = fit(wide_t'(wl[l]) - wide_t'(sp[l]));
        end
    end

    always_comb begin
        zw     = wide_t'(acc_q >>> FRAC) + wide_t'(b_q);
        dz_new = fit(wide_t'(y_q) - wide_t'(yt_q));
        g_new  = fit((wide_t'(lr_q) * wide_t'(dz_new)) >>> FRAC);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        x_d     = x_q;
        b_d     = b_q;
        y_d     = y_q;
        dz_d    = dz_q;
        g_d     = g_q;
        yt_d    = yt_q;
        lr_d    = lr_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load_w) begin
                    for (int i = 0; i < N; i++)
                        w_d[i] = bus.w_in[i*BITS +: BITS];
                    b_d = bus.b_in;
                end else if (bus.start && !bus.mode) begin
                    for (int i = 0; i < N; i++)
                        x_d[i] = bus.x[i*BITS +: BITS];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = FMAC;
                end else if (bus.start) begin
                    yt_d    = bus.y_true;
                    lr_d    = bus.lr;
                    cnt_d   = '0;
                    state_d = BDZ;
                end
            end
            FMAC: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(K - 1)) begin
                    cnt_d   = '0;
                    state_d = FACT;
                end
            end
            FACT: begin
                y_d     = sigmoid(fit(zw));
                done_d  = 1'b1;
                state_d = IDLE;
            end
            BDZ: begin
                dz_d    = dz_new;
                g_d     = g_new;
                state_d = BUPD;
            end
            BUPD: begin
                for (int i = 0; i < N; i++) begin
                    if (CW'(i / LANES) == cnt_q)
                        w_d[i] = wn[i % LANES];
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(K - 1)) begin
                    cnt_d   = '0;
                    state_d = BBIAS;
                end
            end
            BBIAS: begin
                b_d     = fit(wide_t'(b_q) - wide_t'(g_q));
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < N; i++) begin
                w_q[i] <= '0;
                x_q[i] <= '0;
            end
            b_q     <= '0;
            y_q     <= '0;
            dz_q    <= '0;
            g_q     <= '0;
            yt_q    <= '0;
            lr_q    <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            x_q     <= x_d;
            b_q     <= b_d;
            y_q     <= y_d;
            dz_q    <= dz_d;
            g_q     <= g_d;
            yt_q    <= yt_d;
            lr_q    <= lr_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.y     = y_q;
    assign bus.dz    = dz_q;
    assign bus.b_out = b_q;

    for (genvar gi = 0; gi < N; gi++) begin : g_wout
        assign bus.w_out[gi*BITS +: BITS] = w_q[gi];
    end
endmodule

// File: tb/tb_neuron_lane_sigmoid.sv
// Scoreboard bench for neuron_lane_sigmoid (N=4 and N=5, LANES=2).
// Expected results come from a plain-arithmetic model of the neuron.
module tb_neuron_lane_sigmoid;
    localparam int N     = 4;
    localparam int BITS  = 16;
    localparam int FRAC  = 8;
    localparam int LANES = 2;
    localparam int K     = (N + LANES - 1) / LANES;
    localparam longint ONE = 1 << FRAC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errs   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_lane_sigmoid_if #(.N(4), .BITS(16)) b4 ();
    neuron_lane_sigmoid_if #(.N(5), .BITS(16)) b5 ();

    neuron_lane_sigmoid #(.N(4), .BITS(16), .FRAC(8), .LANES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4)
    );
    neuron_lane_sigmoid #(.N(5), .BITS(16), .FRAC(8), .LANES(2)) dut5 (
        .clk(clk), .rst_n(rst_n), .bus(b5)
    );

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] dz;
        logic [15:0] b;
        logic [63:0] w;
        int          lat;
        int          e0;
    } exp_t;

    exp_t   sb[$];
    exp_t   me;
    longint mw[N];
    longint mx[N];
    longint mb, my, mdz;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic longint sx(input logic [15:0] v);
        logic signed [15:0] t;
        t = v;
        return longint'(t);
    endfunction

    function automatic longint fitm(input longint v);
`ifdef NEURON_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        return sx(v[15:0]);
`endif
    endfunction

    function automatic longint sigm(input longint z);
        longint a, p;
        a = (z < 0) ? -z : z;
        if (a >= 5 * ONE)            p = ONE;
        else if (a >= 19 * ONE / 8)  p = a / 32 + 27 * ONE / 32;
        else if (a >= ONE)           p = a / 8 + 5 * ONE / 8;
        else                         p = a / 4 + ONE / 2;
        return (z < 0) ? ONE - p : p;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mw[i] = 0;
            mx[i] = 0;
        end
        mb = 0; my = 0; mdz = 0;
    endfunction

    function automatic void push(input int lat, input int e0);
        exp_t e;
        e.y  = my[15:0];
        e.dz = mdz[15:0];
        e.b  = mb[15:0];
        for (int i = 0; i < N; i++) e.w[i*16 +: 16] = mw[i][15:0];
        e.lat = lat;
        e.e0  = e0;
        sb.push_back(e);
    endfunction

    function automatic logic [15:0] rv();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 1023)) - 16'd512;
    endfunction

    task automatic load(input logic [63:0] w, input logic [15:0] b);
        b4.w_in = w; b4.b_in = b; b4.load_w = 1'b1;
        @(posedge clk); #1;
        b4.load_w = 1'b0;
        for (int i = 0; i < N; i++) mw[i] = sx(w[i*16 +: 16]);
        mb = sx(b);
    endtask

    task automatic fwd(input logic [63:0] xv);
        longint acc;
        b4.x = xv; b4.mode = 1'b0; b4.start = 1'b1;
        @(posedge clk); #1;
        b4.start = 1'b0;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            mx[i] = sx(xv[i*16 +: 16]);
            acc += mx[i] * mw[i];
        end
        my = sigm(fitm((acc >>> FRAC) + mb));
        push(K + 1, cyc);
    endtask

    task automatic bwd(input logic [15:0] yt, input logic [15:0] lr);
        longint g;
        b4.y_true = yt; b4.lr = lr; b4.mode = 1'b1; b4.start = 1'b1;
        @(posedge clk); #1;
        b4.start = 1'b0;
        mdz = fitm(my - sx(yt));
        g   = fitm((sx(lr) * mdz) >>> FRAC);
        for (int i = 0; i < N; i++)
            mw[i] = fitm(mw[i] - fitm((g * mx[i]) >>> FRAC));
        mb = fitm(mb - g);
        push(K + 2, cyc);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!b4.busy) return;
        end
        checks++; errs++;
        $display("FAIL idle_timeout: busy=1 after 40 cycles, expected 0");
    endtask

    always @(negedge clk) begin
        if (rst_n && b4.done) begin
            if (sb.size() == 0) begin
                checks++; errs++;
                $display("FAIL done_spurious: done=1 with no pass outstanding, expected 0");
            end else begin
                me = sb.pop_front();
                chk("mon_y", 64'(b4.y), 64'(me.y));
                chk("mon_dz", 64'(b4.dz), 64'(me.dz));
                chk("mon_b", 64'(b4.b_out), 64'(me.b));
                chk("mon_w", b4.w_out, me.w);
                chk("mon_lat", 64'(cyc - me.e0), 64'(me.lat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  e0;
        bit  got;
        b4.start = 0; b4.mode = 0; b4.load_w = 0; b4.w_in = '0; b4.b_in = '0;
        b4.x = '0; b4.y_true = '0; b4.lr = '0;
        b5.start = 0; b5.mode = 0; b5.load_w = 0; b5.w_in = '0; b5.b_in = '0;
        b5.x = '0; b5.y_true = '0; b5.lr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_y", 64'(b4.y), 64'h0);
        chk("rst_dz", 64'(b4.dz), 64'h0);
        chk("rst_b", 64'(b4.b_out), 64'h0);
        chk("rst_w", b4.w_out, 64'h0);
        chk("rst_busy", 64'(b4.busy), 64'h0);
        chk("rst_done", 64'(b4.done), 64'h0);

        // N=5 partial last group: z = 5.0, done at edge K+1 = 4
        b5.w_in = {5{16'h0100}}; b5.b_in = '0; b5.load_w = 1'b1;
        @(posedge clk); #1;
        b5.load_w = 1'b0;
        b5.x = {5{16'h0100}}; b5.mode = 1'b0; b5.start = 1'b1;
        @(posedge clk); #1;
        b5.start = 1'b0;
        e0 = cyc;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (b5.done) begin
                got = 1;
                chk("n5_lat", 64'(cyc - e0), 64'd4);
                chk("n5_y", 64'(b5.y), 64'h0100);
            end
        end
        if (!got) begin
            checks++; errs++;
            $display("FAIL n5_timeout: no done within 20 cycles, expected done at edge 4");
        end

        load(64'h0200_FF00_0080_0100, 16'h0000);
        fwd(64'h0080_0100_0100_0100);
        wait_idle();
        chk("s1_y", 64'(b4.y), 64'h00D0);
        bwd(16'h0100, 16'h0080);
        wait_idle();
        chk("s2_dz", 64'(b4.dz), 64'hFFD0);
        chk("s2_w", b4.w_out, 64'h020C_FF18_0098_0118);
        chk("s2_b", 64'(b4.b_out), 64'h0018);

        load(64'hFE00_0100_FF80_FF00, 16'h0000);
        fwd(64'h0080_0100_0100_0100);
        wait_idle();
        chk("s3_y", 64'(b4.y), 64'h0030);

        load(64'h7FF0_0000_0000_0000, 16'h0000);
        fwd(64'h0100_0000_0000_0000);
        wait_idle();
        chk("sat_y", 64'(b4.y), 64'h0100);
        bwd(16'h0120, 16'h0100);
        wait_idle();
        chk("sat_dz", 64'(b4.dz), 64'hFFE0);
`ifdef NEURON_SAT_EN
        chk("sat_w3", 64'(b4.w_out[63:48]), 64'h7FFF);
`else
        chk("sat_w3", 64'(b4.w_out[63:48]), 64'h8010);
`endif
        chk("sat_b", 64'(b4.b_out), 64'h0020);

        // start/load_w while busy must be dropped
        load(64'h0040_0030_0020_0010, 16'h0005);
        fwd({rv(), rv(), rv(), rv()});
        b4.start = 1'b1; b4.mode = 1'b1; b4.load_w = 1'b1;
        b4.w_in = 64'h1111_2222_3333_4444; b4.b_in = 16'h7777;
        @(posedge clk); #1;
        b4.start = 1'b0; b4.load_w = 1'b0;
        wait_idle();
        chk("busy_w", b4.w_out, 64'h0040_0030_0020_0010);
        chk("busy_b", 64'(b4.b_out), 64'h0005);

        // load_w has priority over start in the same cycle
        b4.w_in = 64'h0123_0456_0789_0ABC; b4.b_in = 16'h0042;
        b4.load_w = 1'b1; b4.start = 1'b1; b4.mode = 1'b0;
        @(posedge clk); #1;
        b4.load_w = 1'b0; b4.start = 1'b0;
        for (int i = 0; i < N; i++) mw[i] = sx(b4.w_in[i*16 +: 16]);
        mb = 16'h0042;
        repeat (3) begin
            @(negedge clk);
            chk("ls_busy", 64'(b4.busy), 64'h0);
        end
        chk("ls_w", b4.w_out, 64'h0123_0456_0789_0ABC);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       load({rv(), rv(), rv(), rv()}, rv());
                1, 2:    fwd({rv(), rv(), rv(), rv()});
                default: bwd(rv(), rv());
            endcase
            wait_idle();
        end

        // reset in the middle of the weight update
        load({rv(), rv(), rv(), rv()}, rv());
        fwd({rv(), rv(), rv(), rv()});
        wait_idle();
        bwd(rv(), rv());
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        sb.delete();
        model_reset();
        chk("mid_y", 64'(b4.y), 64'h0);
        chk("mid_dz", 64'(b4.dz), 64'h0);
        chk("mid_b", 64'(b4.b_out), 64'h0);
        chk("mid_w", b4.w_out, 64'h0);
        chk("mid_busy", 64'(b4.busy), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        bwd(rv(), rv());
        wait_idle();
        for (int it = 0; it < 10; it++) begin
            if (it % 3 == 0) load({rv(), rv(), rv(), rv()}, rv());
            if (it % 2 == 0) fwd({rv(), rv(), rv(), rv()});
            else             bwd(rv(), rv());
            wait_idle();
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/neuron_lane_sigmoid.md
# neuron_lane_sigmoid

Parametrised fixed-point sigmoid neuron with an internal weight/bias register file, `LANES` parallel multipliers and an explicit forward/backward state machine. It uses a start/busy/done handshake.
- Forward pass: computes `y = sigmoid(sum(x_i*w_i) + b)`.
- Backward pass: computes `dz = y - y_true` and updates every weight and the bias in place by gradient descent.
- It is the layer-level building block that replaces the fixed N=30, two-multiplier sigmoid neuron in the network datapath.

## Interface
- `N`, 30: number of inputs/weights.
- `BITS`, 16: signed two's-complement word width.
- `FRAC`, 8: fractional bits (Q(BITS-FRAC).FRAC).
- `LANES`, 2: multipliers used per MAC/update cycle (1..N).
- `clk`  in  1  — clock; all state on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — begin pass; sampled only in IDLE.
- `mode`  in  1  — 0 forward, 1 backward; sampled with `start`.
- `load_w`  in  1  — load `w_in`/`b_in` into weight file; IDLE only.
- `w_in`  in  N*BITS  — weights, w[i] at bits [i*BITS +: BITS].
- `b_in`  in  BITS  — bias.
- `x`  in  N*BITS  — inputs; latched into x_reg on forward start.
- `y_true`  in  BITS  — target; latched on backward start.
- `lr`  in  BITS  — learning rate; latched on backward start.
- `busy`  out  1  — high in any non-IDLE state.
- `done`  out  1  — one-cycle pulse at pass completion.
- `y`  out  BITS  — registered activation.
- `dz`  out  BITS  — registered error `y - y_true`.
- `w_out`  out  N*BITS  — current weight file.
- `b_out`  out  BITS  — current bias.

## Operation
- Reset values:
  - All outputs are 0.
  - Weight file, bias, x_reg, accumulator and gradient `g` are 0.
  - State is IDLE.
- K = ceil(N/LANES). Lanes beyond N in the last group contribute 0 and write nothing.
- States are IDLE, FMAC, FACT, BDZ, BUPD, BBIAS.
- IDLE behaviour:
  - `load_w` has priority: it loads w/b, and `start` in the same cycle is ignored.
  - Otherwise, `start` with `mode=0` clears the accumulator, latches x and goes to FMAC.
  - Otherwise, `start` with `mode=1` latches `y_true`/`lr` and goes to BDZ.
- FMAC: for K cycles, add LANES full-precision products `x_i*w_i` (2*BITS each) into an accumulator of width 2*BITS+clog2(N)+1. Then go to FACT.
- FACT:
  - z = (acc >>> FRAC) + b, arithmetic shift, truncate toward -inf.
  - z is resized to BITS.
  - y <= sigmoid(z); `done` is pulsed; next state is IDLE.
- Sigmoid uses the PLAN approximation on a = |z|:
  - a ≥ 5.0: 1.0.
  - 2.375 ≤ a < 5.0: a/32 + 0.84375.
  - 1.0 ≤ a < 2.375: a/8 + 0.625.
  - a < 1.0: a/4 + 0.5.
  - For z < 0, the result is 1.0 - that value. Shifts truncate.
- BDZ: dz <= y - y_true; g <= (lr*dz) >>> FRAC, computed from the new dz combinationally.
- BUPD: for K cycles, w_i <= w_i - ((g*x_reg_i) >>> FRAC) for LANES weights per cycle, ascending index.
- BBIAS: b <= b - g; `done` is pulsed; next state is IDLE.
- Backward uses the y and x_reg of the most recent forward pass. After reset, both are 0.
- `start`/`load_w` while busy are ignored, with no queueing. `mode` changes mid-pass have no effect.
- rst_n low at any time, including mid-pass, immediately restores all reset values.

## Timing
- Forward: `start` is sampled at edge 0. `done`/`y` are updated at edge K+1.
- Backward: `start` is sampled at edge 0. `dz`/`g` are updated at edge 1, the last weight at edge K+1, and the bias plus `done` at edge K+2.
- `busy` rises at the edge after `start` and falls at the edge that raises `done`. A new `start` is accepted in the cycle `done` is high.
- `w_out` reflects each lane write from the edge it occurs.

## Configuration
- `NEURON_SAT_EN` defined: these results clamp to [-2^(BITS-1), 2^(BITS-1)-1]:
  - z after resize;
  - dz;
  - g;
  - each scaled product;
  - each w/b update.
- `NEURON_SAT_EN` undefined: the same results truncate to BITS and wrap in two's complement.
- The sigmoid output is always in [0, 1.0] regardless of the macro.

## Test plan
All scenarios use BITS=16, FRAC=8, N=4, LANES=2, so K=2.

- **Forward, positive z.** Load w=[0x0100,0x0080,0xFF00,0x0200], b=0. Apply x=[0x0100,0x0100,0x0100,0x0080] and a forward start. Expect z=1.5, y=0x00D0, and `done` at edge 3.
- **Backward update.** Following the first scenario, run backward with y_true=0x0100, lr=0x0080. Expect:
  - dz=0xFFD0 and g=0xFFE8;
  - w=[0x0118,0x0098,0xFF18,0x020C], b=0x0018;
  - `done` at edge 4.
- **Forward, negative z.** Load w=[0xFF00,0xFF80,0x0100,0xFE00], b=0 with the same x. Expect y=0x0030.
- **Saturation.**
  - Setup: load w=[0,0,0,0x7FF0], b=0, x=[0,0,0,0x0100]. A forward pass gives y=0x0100.
  - Backward: run with y_true=0x0120, lr=0x0100, giving dz=g=0xFFE0.
  - With `NEURON_SAT_EN`: w3=0x7FFF. Without it: w3=0x8010.
  - In both builds b=0x0020.
- **Handshake.**
  - `start` and `load_w` pulsed while busy are ignored: the weights are unchanged and exactly one `done` is produced.
  - `load_w` and `start` in the same IDLE cycle: the load happens and no pass starts.
  - rst_n pulsed during BUPD: all outputs and weights read 0 and `busy`=0.
- **Partial last lane group (N=5, LANES=2).** With all x and w equal to 0x0100 and b=0, expect z=5.0, y=0x0100, and forward `done` at edge 4.
